// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide step per clock,
// started with a start pulse and finished with a one-cycle done pulse.
module muldiv_seq #(
    parameter int DW = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic          abort,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] res_lo,
    output logic [DW-1:0] res_hi,
    output logic          dz,
    output logic [1:0]    state_dbg
);

    // Handshake: start is sampled only when not busy (IDLE or DONE); done is a
    // one-cycle pulse and results stay valid until the next done.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic            op_r;
    logic [DW-1:0]   opnd;      // multiplicand (mul) or divisor (div)
    logic [2*DW-1:0] acc;       // {hi, lo}: {product hi, multiplier} or {rem, quo}
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            div_zero;
    logic            last_iter;
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW:0]     rem_sh;
    logic [DW:0]     trial;
    logic [2*DW-1:0] div_next;
    logic [2*DW-1:0] acc_nx;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign div_zero  = accept && op && (b == '0);
    assign last_iter = (cnt == CW'(DW - 1));

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)                state_nx = (op && b == '0) ? S_DONE : S_RUN;
                else if (state == S_DONE) state_nx = S_IDLE;
            end
            S_RUN: begin
                if (abort)          state_nx = S_IDLE;
                else if (last_iter) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // One iteration of each algorithm; the carry out of the add lands in the top bit after the shift.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[DW-1:1]} : {1'b0, acc[2*DW-1:1]};
        rem_sh   = acc[2*DW-1:DW-1];
        trial    = rem_sh - {1'b0, opnd};
        div_next = trial[DW] ? {rem_sh[DW-1:0], acc[DW-2:0], 1'b0}
                             : {trial[DW-1:0],  acc[DW-2:0], 1'b1};
        acc_nx   = op_r ? div_next : mul_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            dz     <= 1'b0;
        end else if (accept) begin
            op_r <= op;
            opnd <= op ? b : a;
            acc  <= {{DW{1'b0}}, op ? a : b};
            cnt  <= '0;
            if (div_zero) begin
                res_lo <= '1;
                res_hi <= a;
                dz     <= 1'b1;
            end
        end else if (state == S_RUN && !abort) begin
            acc <= acc_nx;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
                res_lo <= acc_nx[DW-1:0];
                res_hi <= acc_nx[2*DW-1:DW];
                dz     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes expected {dz, res_hi, res_lo} into a queue
// and a monitor pops and compares on every done pulse.
module tb_muldiv_seq;

    localparam int DW = 16;
    localparam int CW = 5;
    localparam int W  = 2 * DW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy, done, dz;
    logic [DW-1:0] res_lo, res_hi;
    logic [1:0]    state_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done),
        .res_lo(res_lo), .res_hi(res_hi), .dz(dz), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got %h, no result expected", {dz, res_hi, res_lo});
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({dz, res_hi, res_lo} !== e) begin
                    n_err++;
                    $display("FAIL result: got dz=%0b hi=%h lo=%h, expected dz=%0b hi=%h lo=%h",
                             dz, res_hi, res_lo, e[W-1], e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic edz, input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
        exp_q.push_back({edz, ehi, elo});
    endtask

    // drive a one-cycle start; returns 1ns after the accept edge
    task automatic issue(input logic iop, input logic [DW-1:0] ia, input logic [DW-1:0] ib);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        // reset state
        #3;
        chk("reset_outputs", {busy, done, dz, res_hi, res_lo}, '0);
        chk("reset_state", 64'(state_dbg), 64'd0);
        #9 rst = 1'b1;

        // 7 * 6: busy for 16 cycles, then one done cycle
        push_exp(1'b0, 16'h0000, 16'h002A);
        issue(1'b0, 16'd7, 16'd6);
        begin
            int bad = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (!busy || done) bad++;
            end
            chk("busy_window", 64'(bad), 64'd0);
        end
        @(negedge clk);
        chk("done_after_16", {62'd0, busy, done}, 64'd1);
        @(negedge clk);
        chk("done_one_cycle", {62'd0, busy, done}, 64'd0);

        // largest product, then a division
        push_exp(1'b0, 16'hFFFE, 16'h0001);
        issue(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done(40);
        push_exp(1'b0, 16'd2, 16'd14);
        issue(1'b1, 16'd100, 16'd7);
        wait_done(40);

        // divide by zero finishes one cycle after accept
        push_exp(1'b1, 16'h0005, 16'hFFFF);
        issue(1'b1, 16'd5, 16'd0);
        @(negedge clk);
        chk("dz_done_fast", 64'(done), 64'd1);
        push_exp(1'b0, 16'd0, 16'd3);
        issue(1'b1, 16'd9, 16'd3);
        wait_done(40);

        // start held high: each DONE edge accepts the next operation
        push_exp(1'b0, 16'h0001, 16'h2340);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0010;
        @(posedge clk); #1;
        push_exp(1'b0, 16'd10, 16'd30);
        op = 1'b1; a = 16'd1000; b = 16'd33;
        wait_done(40);
        @(posedge clk); #1;
        push_exp(1'b1, 16'h1234, 16'hFFFF);
        op = 1'b1; a = 16'h1234; b = 16'h0000;
        wait_done(40);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5);
        @(negedge clk);
        chk("b2b_idle", {62'd0, busy, done}, 64'd0);

        // start pulse mid-RUN is ignored
        push_exp(1'b0, 16'd0, 16'd15);
        issue(1'b0, 16'd3, 16'd5);
        repeat (4) @(posedge clk);
        #1;
        issue(1'b1, 16'd50, 16'd5);
        wait_done(40);
        repeat (3) @(negedge clk);

        // abort on iteration 5 of a divide
        issue(1'b1, 16'd200, 16'd9);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy_drop", {62'd0, busy, done}, 64'd0);
        chk("abort_hold", {dz, res_hi, res_lo}, {1'b0, 16'd0, 16'd15});
        repeat (20) @(negedge clk);
        push_exp(1'b0, 16'd2, 16'd22);
        issue(1'b1, 16'd200, 16'd9);
        wait_done(40);

        // asynchronous reset mid-RUN
        issue(1'b0, 16'h00FF, 16'h0101);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_reset", {busy, done, dz, res_hi, res_lo}, '0);
        #10 rst = 1'b1;
        push_exp(1'b0, 16'h0000, 16'hFFFF);
        issue(1'b0, 16'h00FF, 16'h0101);
        wait_done(40);
        repeat (3) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
